// File: rtl/control_sequencer.sv
// Microcoded T-state sequencer for an 8-bit SAP-style CPU; optional CTRL_COND_JUMP_EN enables JC/JZ.
// Latency: ctrl_word is a zero-latency decode of step/opcode/flags; state advances one step per clk.
// Backpressure: none; the sequencer free-runs once out of reset and parks in HALT on HLT.
module control_sequencer #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [N/2-1:0]   opcode,
    input  logic             carry_flag,
    input  logic             zero_flag,
    output logic [15:0]      ctrl_word,
    output logic [2:0]       step,
    output logic             halted
);

    localparam int OPW = N / 2;

    localparam logic [2:0] ST_T0   = 3'd0;
    localparam logic [2:0] ST_T1   = 3'd1;
    localparam logic [2:0] ST_T2   = 3'd2;
    localparam logic [2:0] ST_T3   = 3'd3;
    localparam logic [2:0] ST_T4   = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;

    localparam logic [15:0] C_HALT       = 16'h0001;
    localparam logic [15:0] C_MAR_LOAD   = 16'h0002;
    localparam logic [15:0] C_RAM_LOAD   = 16'h0004;
    localparam logic [15:0] C_RAM_OUT    = 16'h0008;
    localparam logic [15:0] C_IR_LOAD    = 16'h0010;
    localparam logic [15:0] C_IR_OUT     = 16'h0020;
    localparam logic [15:0] C_A_LOAD     = 16'h0040;
    localparam logic [15:0] C_A_OUT      = 16'h0080;
    localparam logic [15:0] C_ALU_OUT    = 16'h0100;
    localparam logic [15:0] C_ALU_SUB    = 16'h0200;
    localparam logic [15:0] C_B_LOAD     = 16'h0400;
    localparam logic [15:0] C_OUT_LOAD   = 16'h0800;
    localparam logic [15:0] C_PC_INC     = 16'h1000;
    localparam logic [15:0] C_PC_OUT     = 16'h2000;
    localparam logic [15:0] C_PC_LOAD    = 16'h4000;
    localparam logic [15:0] C_FLAGS_LOAD = 16'h8000;

    localparam logic [OPW-1:0] OP_LDA = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'h2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_STA = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_LDI = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_JMP = OPW'(4'h6);
    localparam logic [OPW-1:0] OP_JC  = OPW'(4'h7);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(4'h8);
    localparam logic [OPW-1:0] OP_OUT = OPW'(4'hE);
    localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

    logic [2:0]  state_q, state_d;
    logic        run_q, run_d;
    logic [2:0]  nxt;
    logic [15:0] ctrl;

`ifdef CTRL_COND_JUMP_EN
    logic jc_take, jz_take;
    assign jc_take = carry_flag;
    assign jz_take = zero_flag;
`else
    logic unused_flags;
    assign unused_flags = carry_flag ^ zero_flag;
`endif

    always_comb begin
        ctrl = 16'h0000;
        nxt  = ST_T0;
        case (state_q)
            ST_T0: begin
                ctrl = C_PC_OUT | C_MAR_LOAD;
                nxt  = ST_T1;
            end
            ST_T1: begin
                ctrl = C_RAM_OUT | C_IR_LOAD | C_PC_INC;
                nxt  = ST_T2;
            end
            ST_T2: begin
                // flags only ever influence the decode here, in T2
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl = C_IR_OUT | C_MAR_LOAD;
                        nxt  = ST_T3;
                    end
                    OP_LDI: ctrl = C_IR_OUT | C_A_LOAD;
                    OP_JMP: ctrl = C_IR_OUT | C_PC_LOAD;
`ifdef CTRL_COND_JUMP_EN
                    OP_JC:  ctrl = C_IR_OUT | (jc_take ? C_PC_LOAD : 16'h0000);
                    OP_JZ:  ctrl = C_IR_OUT | (jz_take ? C_PC_LOAD : 16'h0000);
`endif
                    OP_OUT: ctrl = C_A_OUT | C_OUT_LOAD;
                    OP_HLT: begin
                        ctrl = C_HALT;
                        nxt  = ST_HALT;
                    end
                    default: ctrl = 16'h0000;
                endcase
            end
            ST_T3: begin
                case (opcode)
                    OP_LDA: ctrl = C_RAM_OUT | C_A_LOAD;
                    OP_ADD, OP_SUB: begin
                        ctrl = C_RAM_OUT | C_B_LOAD;
                        nxt  = ST_T4;
                    end
                    OP_STA: ctrl = C_A_OUT | C_RAM_LOAD;
                    default: ctrl = 16'h0000;
                endcase
            end
            ST_T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB)
                    ctrl = C_ALU_OUT | C_A_LOAD | C_FLAGS_LOAD |
                           ((opcode == OP_SUB) ? C_ALU_SUB : 16'h0000);
            end
            ST_HALT: begin
                ctrl = C_HALT;
                nxt  = ST_HALT;
            end
            default: nxt = ST_T0;
        endcase
    end

    // run_q holds the sequencer in T0 for the first edge after reset release
    always_comb begin
        run_d   = 1'b1;
        state_d = run_q ? nxt : ST_T0;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_T0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    assign ctrl_word = clear_n ? ctrl : 16'h0000;
    assign halted    = clear_n && (state_q == ST_HALT);
    assign step      = (!clear_n || state_q == ST_HALT) ? 3'd0 : state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector scoreboard bench for control_sequencer: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares ctrl_word/step/halted.
module tb_control_sequencer;

    logic        clk;
    logic        clear_n;
    logic [3:0]  opcode;
    logic        carry_flag;
    logic        zero_flag;
    logic [15:0] ctrl_word;
    logic [2:0]  step;
    logic        halted;

    control_sequencer #(.N(8)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .ctrl_word  (ctrl_word),
        .step       (step),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] exp_ctrl_q[$];
    logic [2:0]  exp_step_q[$];
    logic        exp_halt_q[$];
    int          total = 0;
    int          bad   = 0;
    int          vec   = 0;

`ifdef CTRL_COND_JUMP_EN
    localparam logic [15:0] JC_TAKEN = 16'h4020;
    localparam logic [15:0] JC_NOT   = 16'h0020;
`else
    localparam logic [15:0] JC_TAKEN = 16'h0000;
    localparam logic [15:0] JC_NOT   = 16'h0000;
`endif

    always @(negedge clk) begin
        if (exp_ctrl_q.size() > 0) begin
            logic [15:0] ec;
            logic [2:0]  es;
            logic        eh;
            ec = exp_ctrl_q.pop_front();
            es = exp_step_q.pop_front();
            eh = exp_halt_q.pop_front();
            total += 3;
            if (ctrl_word !== ec) begin
                bad++;
                $display("FAIL ctrl_word vec%0d: got %h want %h", vec, ctrl_word, ec);
            end
            if (step !== es) begin
                bad++;
                $display("FAIL step vec%0d: got %0d want %0d", vec, step, es);
            end
            if (halted !== eh) begin
                bad++;
                $display("FAIL halted vec%0d: got %0b want %0b", vec, halted, eh);
            end
            vec++;
        end
    end

    task automatic push_exp(input logic [15:0] c, input logic [2:0] s, input logic h);
        exp_ctrl_q.push_back(c);
        exp_step_q.push_back(s);
        exp_halt_q.push_back(h);
    endtask

    // one clock cycle: apply inputs just after the edge, expect outputs for this cycle
    task automatic cyc(input logic rn, input logic [3:0] op, input logic cf, input logic zf,
                       input logic [15:0] c, input logic [2:0] s, input logic h);
        @(posedge clk);
        #1;
        clear_n    = rn;
        opcode     = op;
        carry_flag = cf;
        zero_flag  = zf;
        push_exp(c, s, h);
    endtask

    task automatic fetch(input logic [3:0] op0, input logic [3:0] op1);
        cyc(1'b1, op0, 1'b0, 1'b0, 16'h2002, 3'd0, 1'b0);
        cyc(1'b1, op1, 1'b0, 1'b0, 16'h1018, 3'd1, 1'b0);
    endtask

    initial begin
        clear_n    = 1'b0;
        opcode     = 4'h0;
        carry_flag = 1'b0;
        zero_flag  = 1'b0;

        // reset state, then release: one held T0, then fetch of a NOP
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 16'h2002, 3'd0, 1'b0);
        fetch(4'h0, 4'h0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b0);

        // ADD with opcode noise during fetch and a flag toggle in T3
        fetch(4'h5, 4'hF);
        cyc(1'b1, 4'h2, 1'b0, 1'b0, 16'h0022, 3'd2, 1'b0);
        cyc(1'b1, 4'h2, 1'b1, 1'b1, 16'h0408, 3'd3, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0, 16'h8140, 3'd4, 1'b0);

        // SUB
        fetch(4'h3, 4'h3);
        cyc(1'b1, 4'h3, 1'b0, 1'b0, 16'h0022, 3'd2, 1'b0);
        cyc(1'b1, 4'h3, 1'b0, 1'b0, 16'h0408, 3'd3, 1'b0);
        cyc(1'b1, 4'h3, 1'b0, 1'b0, 16'h8340, 3'd4, 1'b0);

        // LDA, LDI, JMP
        fetch(4'h1, 4'h1);
        cyc(1'b1, 4'h1, 1'b0, 1'b0, 16'h0022, 3'd2, 1'b0);
        cyc(1'b1, 4'h1, 1'b0, 1'b0, 16'h0048, 3'd3, 1'b0);
        fetch(4'h5, 4'h5);
        cyc(1'b1, 4'h5, 1'b0, 1'b0, 16'h0060, 3'd2, 1'b0);
        fetch(4'h6, 4'h6);
        cyc(1'b1, 4'h6, 1'b0, 1'b0, 16'h4020, 3'd2, 1'b0);

        // conditional jumps, taken and untaken (wrong flag set for untaken)
        fetch(4'h7, 4'h7);
        cyc(1'b1, 4'h7, 1'b1, 1'b0, JC_TAKEN, 3'd2, 1'b0);
        fetch(4'h7, 4'h7);
        cyc(1'b1, 4'h7, 1'b0, 1'b1, JC_NOT, 3'd2, 1'b0);
        fetch(4'h8, 4'h8);
        cyc(1'b1, 4'h8, 1'b0, 1'b1, JC_TAKEN, 3'd2, 1'b0);
        fetch(4'h8, 4'h8);
        cyc(1'b1, 4'h8, 1'b1, 1'b0, JC_NOT, 3'd2, 1'b0);

        // undefined opcode is a NOP
        fetch(4'hB, 4'hB);
        cyc(1'b1, 4'hB, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b0);

        // STA then OUT back-to-back
        fetch(4'h4, 4'h4);
        cyc(1'b1, 4'h4, 1'b0, 1'b0, 16'h0022, 3'd2, 1'b0);
        cyc(1'b1, 4'h4, 1'b0, 1'b0, 16'h0084, 3'd3, 1'b0);
        fetch(4'hE, 4'hE);
        cyc(1'b1, 4'hE, 1'b0, 1'b0, 16'h0880, 3'd2, 1'b0);

        // ADD aborted by reset asserted between edges during T3
        fetch(4'h2, 4'h2);
        cyc(1'b1, 4'h2, 1'b0, 1'b0, 16'h0022, 3'd2, 1'b0);
        @(posedge clk);
        #2;
        clear_n = 1'b0;
        push_exp(16'h0000, 3'd0, 1'b0);
        cyc(1'b0, 4'h2, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0, 16'h2002, 3'd0, 1'b0);
        fetch(4'h0, 4'h0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b0);

        // HLT: parks in HALT regardless of inputs until clear_n
        fetch(4'hF, 4'hF);
        cyc(1'b1, 4'hF, 1'b0, 1'b0, 16'h0001, 3'd2, 1'b0);
        for (int i = 0; i < 12; i++)
            cyc(1'b1, 4'(i), i[0], i[1], 16'h0001, 3'd0, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 16'h2002, 3'd0, 1'b0);
        fetch(4'h0, 4'h0);

        repeat (3) @(negedge clk);
        total++;
        if (exp_ctrl_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_ctrl_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter N SHALL default to 8 and set the datapath width; the opcode width SHALL be N/2.
REQ-003 Port clk SHALL be an input, 1 bit wide, carrying the system clock; all state SHALL update on its rising edge.
REQ-004 Port clear_n SHALL be an input, 1 bit wide, carrying the asynchronous active-low reset.
REQ-005 Port opcode SHALL be an input, N/2 bits wide, driven by the instruction register controller nibble.
REQ-006 Port carry_flag SHALL be an input, 1 bit wide, carrying the registered ALU carry.
REQ-007 Port zero_flag SHALL be an input, 1 bit wide, carrying the registered ALU zero.
REQ-008 Port ctrl_word SHALL be an output, 16 bits wide, carrying the control word for the current step.
REQ-009 Port step SHALL be an output, 3 bits wide, carrying the current T-state (0 to 4).
REQ-010 Port halted SHALL be an output, 1 bit wide, asserted while the block is in HALT.

Function
REQ-011 The ctrl_word bit map SHALL be: 0 halt, 1 mar_load, 2 ram_load, 3 ram_out, 4 ir_load, 5 ir_out, 6 a_load, 7 a_out, 8 alu_out, 9 alu_sub, 10 b_load, 11 out_load, 12 pc_inc, 13 pc_out, 14 pc_load, 15 flags_load.
REQ-012 ctrl_word SHALL be a combinational decode of step, opcode and the flags, with zero added latency; every bit not listed for a step SHALL be 0.
REQ-013 The states SHALL be T0..T4 plus HALT; after reset the state SHALL be T0.
REQ-014 T0 SHALL assert pc_out and mar_load; the next state SHALL be T1.
REQ-015 T1 SHALL assert ram_out, ir_load and pc_inc; the next state SHALL be T2.
REQ-016 In T2..T4, execute steps SHALL decode opcode as follows:
- 0x1 LDA: T2 ir_out+mar_load; T3 ram_out+a_load.
- 0x2 ADD: T2 ir_out+mar_load; T3 ram_out+b_load; T4 alu_out+a_load+flags_load.
- 0x3 SUB: same as ADD, plus alu_sub in T4.
- 0x4 STA: T2 ir_out+mar_load; T3 a_out+ram_load.
- 0x5 LDI: T2 ir_out+a_load.
- 0x6 JMP: T2 ir_out+pc_load.
- 0x7 JC: T2 ir_out, plus pc_load only if carry_flag=1.
- 0x8 JZ: T2 ir_out, plus pc_load only if zero_flag=1.
- 0xE OUT: T2 a_out+out_load.
- 0xF HLT: T2 halt.
- All other opcodes: NOP, with ctrl_word=0 in T2.
REQ-017 Early return: after an instruction's last listed step, the next state SHALL be T0; NOP and an untaken JC/JZ SHALL return to T0 from T2; T4 SHALL always return to T0.
REQ-018 Flags SHALL be sampled combinationally during T2 only; flag changes in other steps SHALL have no effect.
REQ-019 HLT in T2 SHALL move the state to HALT on the next edge.
REQ-020 In HALT, ctrl_word SHALL be 0x0001, halted SHALL be 1, step SHALL read 0, and the state SHALL remain HALT until clear_n is asserted.
REQ-021 A change of opcode during T0/T1 SHALL NOT alter the fetch ctrl_word.

Reset
REQ-022 While clear_n=0, the state SHALL be forced to T0 immediately (asynchronously), with ctrl_word=0x0000, step=0 and halted=0.
REQ-023 Reset asserted mid-instruction or in HALT SHALL abort the instruction with no partial control pulse.
REQ-024 The first rising clk edge after clear_n deasserts SHALL leave the state in T0; fetch then proceeds normally from T0.

Configuration
REQ-025 Macro CTRL_COND_JUMP_EN SHALL control conditional jumps.
- Defined: JC and JZ SHALL behave per REQ-016.
- Undefined: opcodes 0x7 and 0x8 SHALL decode as NOP, and carry_flag and zero_flag SHALL be unused.

Verification
REQ-026 Reset then 2 clocks with opcode=0x0 -> ctrl_word 0x2002, then 0x1018, then 0x0000 in T2, then back to T0 (0x2002).
REQ-027 ADD (opcode=0x2) -> T2..T4 ctrl_word 0x0022, 0x0408, 0x8140; then T0.
REQ-028 JC with carry_flag=1 -> T2 ctrl_word 0x4020. With carry_flag=0 -> T2 ctrl_word 0x0020, then T0. With the macro undefined -> T2 ctrl_word 0x0000.
REQ-029 HLT (opcode=0xF) -> T2 ctrl_word 0x0001, then HALT holds 0x0001 and halted=1 for 10 or more clocks; clear_n pulse -> ctrl_word 0x0000, state T0.
REQ-030 clear_n asserted between edges during ADD T3 -> ctrl_word 0x0000 immediately with no wait for a clock edge; after release, sequence restarts at T0.
REQ-031 STA then OUT back-to-back -> T2 0x0022, T3 0x0084, T0, T1, T2 0x0880.
